// File: rtl/axi_pkg.sv
// Shared AXI constants, the DMA read FSM state type and a width helper.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_FIN
    } dma_rd_state_t;

    // Ceiling log2 for elaboration-time width and shift calculations.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_dma_rd_master_burst_len.sv
// Burst length for the next read: the smallest of the beats still owed,
// MAX_BURST and the beats left before the next 4 KB page boundary.
module axi_burst_len
    import axi_pkg::*;
#(
    parameter int AXI_DATA_WD = 32,
    parameter int LEN_WD      = 16,
    parameter int MAX_BURST   = 16
) (
    input  logic [11:0]       addr,
    input  logic [LEN_WD-1:0] rem_beats,
    output logic [8:0]        blen
);

    localparam int BYTES_LOG2 = clog2(AXI_DATA_WD / 8);

    logic [12:0] page_bytes;
    logic [12:0] page_beats;
    logic [8:0]  step_cap;

    // Thirteen bits so a page-aligned address yields a full 4096-byte page.
    always_comb begin
        page_bytes = 13'd4096 - {1'b0, addr};
        page_beats = page_bytes >> BYTES_LOG2;
        if (rem_beats < LEN_WD'(MAX_BURST)) step_cap = rem_beats[8:0];
        else                                 step_cap = 9'(MAX_BURST);
        if ({4'b0000, step_cap} > page_beats) blen = page_beats[8:0];
        else                                    blen = step_cap;
    end

endmodule

// File: rtl/axi_dma_rd_master.sv
// DMA read engine: splits one {addr, byte count} command into INCR bursts
// (one outstanding at a time) and forwards read data to a registered stream.
module axi_dma_rd_master
    import axi_pkg::*;
#(
    parameter int AXI_ID_WD   = 2,
    parameter int AXI_DATA_WD = 32,
    parameter int AXI_ADDR_WD = 32,
    parameter int LEN_WD      = 16,
    parameter int MAX_BURST   = 16,
    parameter int RD_ID       = 0
) (
    input  logic                   M_AXI_ACLK,
    input  logic                   M_AXI_ARESETN,
    input  logic [AXI_ADDR_WD-1:0] cmd_addr,
    input  logic [LEN_WD-1:0]      cmd_len,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    output logic [AXI_ADDR_WD-1:0] M_AXI_ARADDR,
    output logic [AXI_ID_WD-1:0]   M_AXI_ARID,
    output logic [1:0]             M_AXI_ARBURST,
    output logic [2:0]             M_AXI_ARSIZE,
    output logic [7:0]             M_AXI_ARLEN,
    output logic                   M_AXI_ARVALID,
    input  logic                   M_AXI_ARREADY,
    input  logic [AXI_DATA_WD-1:0] M_AXI_RDATA,
    input  logic                   M_AXI_RLAST,
    input  logic [AXI_ID_WD-1:0]   M_AXI_RID,
    input  logic [1:0]             M_AXI_RRESP,
    input  logic                   M_AXI_RVALID,
    output logic                   M_AXI_RREADY,
    output logic [AXI_DATA_WD-1:0] out_data,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   done,
    output logic                   err
);

    localparam int BYTES_LOG2 = clog2(AXI_DATA_WD / 8);

    dma_rd_state_t          state;
    logic [AXI_ADDR_WD-1:0] addr;
    logic [LEN_WD-1:0]      rem_beats;
    logic [LEN_WD-1:0]      cmd_beats;
    logic [8:0]             blen;
    logic                   out_free;
    logic                   ar_fire;
    logic                   r_fire;
    logic                   unused_rid;

    // Only one burst is ever in flight, so RID carries no information.
    assign unused_rid = ^M_AXI_RID;

    assign cmd_beats     = cmd_len >> BYTES_LOG2;
    assign out_free      = !out_valid || out_ready;
    assign M_AXI_RREADY  = out_free;
    assign ar_fire       = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_fire        = M_AXI_RVALID && out_free && (state == ST_DATA);

    // addr and rem_beats only change on AR fire, so ARADDR/ARLEN stay stable while stalled.
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARLEN   = 8'(blen - 9'd1);
    assign M_AXI_ARID    = AXI_ID_WD'(RD_ID);
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARSIZE  = 3'(BYTES_LOG2);

    axi_burst_len #(
        .AXI_DATA_WD (AXI_DATA_WD),
        .LEN_WD      (LEN_WD),
        .MAX_BURST   (MAX_BURST)
    ) u_burst_len (
        .addr      (addr[11:0]),
        .rem_beats (rem_beats),
        .blen      (blen)
    );

    // Command FSM plus stream valid/last and status; addr/rem_beats are not reset.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b1;
            M_AXI_ARVALID <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_fire) begin
                out_valid <= 1'b1;
                out_last  <= M_AXI_RLAST && (rem_beats == '0);
                if (M_AXI_RRESP != AXI_RESP_OKAY) err <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        err       <= 1'b0;
                        addr      <= cmd_addr;
                        rem_beats <= cmd_beats;
                        if (cmd_beats == '0) begin
                            state <= ST_FIN;
                        end else begin
                            state         <= ST_ADDR;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (ar_fire) begin
                        M_AXI_ARVALID <= 1'b0;
                        addr          <= addr + (AXI_ADDR_WD'(blen) << BYTES_LOG2);
                        rem_beats     <= rem_beats - LEN_WD'(blen);
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_fire && M_AXI_RLAST) begin
                        if (rem_beats != '0) begin
                            state         <= ST_ADDR;
                            M_AXI_ARVALID <= 1'b1;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    if (out_free) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stream data register; loads on every accepted read beat.
    always_ff @(posedge M_AXI_ACLK) begin
        if (r_fire) out_data <= M_AXI_RDATA;
    end

endmodule

// File: tb/tb_axi_dma_rd_master.sv
// Directed bench for axi_dma_rd_master with a behavioural AXI read slave
// and a burst/beat model computed from the splitting rules.
module tb_axi_dma_rd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] araddr;
    logic [1:0]  arid;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic [1:0]  rid;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    axi_dma_rd_master dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARID    (arid),
        .M_AXI_ARBURST (arburst),
        .M_AXI_ARSIZE  (arsize),
        .M_AXI_ARLEN   (arlen),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RLAST   (rlast),
        .M_AXI_RID     (rid),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .done          (done),
        .err           (err)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [31:0] data; logic last; } beat_t;
    ar_t   exp_ar[$];
    beat_t exp_beat[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'hC0FF_EE00;
    endfunction

    // Model: split the command by plain arithmetic into bursts and beats.
    task automatic model_cmd(input logic [31:0] a0, input int len);
        logic [31:0] a;
        int beats, page, b;
        a = a0;
        beats = len / 4;
        while (beats > 0) begin
            page = (4096 - int'(a[11:0])) / 4;
            b = beats;
            if (b > 16) b = 16;
            if (b > page) b = page;
            exp_ar.push_back('{a, 8'(b - 1)});
            for (int i = 0; i < b; i++)
                exp_beat.push_back('{mem_word(a + 32'(4 * i)), (beats == b) && (i == b - 1)});
            a = a + 32'(4 * b);
            beats -= b;
        end
    endtask

    // Slave configuration and state
    int          ar_delay  = 0;
    int          err_beat  = -1;
    bit          out_tog   = 1'b0;
    int          beat_idx  = 0;
    int          out_fires = 0;
    int          n_stall   = 0;
    bit          sl_busy;
    int          sl_wait;
    logic [31:0] sl_cur;
    int          sl_left;

    task present_beat();
        rvalid = 1'b1;
        rdata  = mem_word(sl_cur);
        rlast  = (sl_left == 0);
        rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
    endtask

    // Behavioural AXI read slave and out_ready pattern generator.
    initial begin
        logic s_rst, s_ar, s_r, s_last, s_arv;
        logic [31:0] s_addr;
        logic [7:0]  s_len;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = '0; rid = '0;
        sl_busy = 1'b0; sl_wait = 0; sl_cur = '0; sl_left = 0;
        forever begin
            @(negedge clk);
            s_rst = rst_n; s_ar = arvalid && arready; s_r = rvalid && rready;
            s_last = rlast; s_arv = arvalid; s_addr = araddr; s_len = arlen;
            @(posedge clk);
            #1;
            if (!s_rst) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; sl_busy = 1'b0; sl_wait = 0;
            end else begin
                if (s_r) begin
                    beat_idx++;
                    if (s_last) begin
                        rvalid = 1'b0; rlast = 1'b0; sl_busy = 1'b0;
                    end else begin
                        sl_cur = sl_cur + 32'd4; sl_left--;
                        present_beat();
                    end
                end
                if (s_ar) begin
                    arready = 1'b0; sl_busy = 1'b1; sl_cur = s_addr; sl_left = int'(s_len); sl_wait = 0;
                    present_beat();
                end else if (!sl_busy && s_arv && !arready) begin
                    if (sl_wait >= ar_delay) arready = 1'b1;
                    else sl_wait++;
                end
            end
            if (out_tog) out_ready = !out_ready;
            else         out_ready = 1'b1;
        end
    end

    // Compare process: checks AR requests and stream beats against the model every cycle.
    initial begin
        bit          stall_prev = 1'b0;
        logic [31:0] prev_addr;
        logic [7:0]  prev_len;
        ar_t         ea;
        beat_t       eb;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rready_rule", 64'(rready), 64'(!out_valid || out_ready));
                if (stall_prev && arvalid) begin
                    n_stall++;
                    chk("araddr_stable", 64'(araddr), 64'(prev_addr));
                    chk("arlen_stable", 64'(arlen), 64'(prev_len));
                end
                stall_prev = arvalid && !arready;
                prev_addr  = araddr;
                prev_len   = arlen;
                if (arvalid && arready) begin
                    n_checks++;
                    if (exp_ar.size() == 0) begin
                        n_errs++;
                        $display("FAIL ar_unexpected: got addr 0x%0h len %0d, none required", araddr, arlen);
                    end else begin
                        n_checks--;
                        ea = exp_ar.pop_front();
                        chk("araddr", 64'(araddr), 64'(ea.addr));
                        chk("arlen", 64'(arlen), 64'(ea.len));
                        chk("arsize", 64'(arsize), 64'(3'd2));
                        chk("arburst", 64'(arburst), 64'(2'b01));
                        chk("arid", 64'(arid), 64'(2'd0));
                    end
                end
                if (out_valid && out_ready) begin
                    out_fires++;
                    n_checks++;
                    if (exp_beat.size() == 0) begin
                        n_errs++;
                        $display("FAIL beat_unexpected: got data 0x%0h, none required", out_data);
                    end else begin
                        n_checks--;
                        eb = exp_beat.pop_front();
                        chk("out_data", 64'(out_data), 64'(eb.data));
                        chk("out_last", 64'(out_last), 64'(eb.last));
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic issue_cmd(input logic [31:0] a, input int len);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        cmd_addr = a; cmd_len = 16'(len); cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; break; end
        end
        chk("cmd_accepted", 64'(got), 64'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input bit exp_err);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        chk("done_seen", 64'(got), 64'(1));
        chk("err_at_done", 64'(err), 64'(exp_err));
        chk("ar_all_issued", 64'(exp_ar.size()), 64'(0));
        chk("beats_all_out", 64'(exp_beat.size()), 64'(0));
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("cmd_ready_after_done", 64'(cmd_ready), 64'(1));
        chk("err_sticky", 64'(err), 64'(exp_err));
    endtask

    task automatic run_cmd(input logic [31:0] a, input int len, input bit exp_err);
        issue_cmd(a, len);
        @(negedge clk);
        chk("err_clear_on_accept", 64'(err), 64'(0));
        wait_done(exp_err);
    endtask

    initial begin
        bit got;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_arvalid", 64'(arvalid), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_rready", 64'(rready), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single 16-beat burst
        model_cmd(32'h100, 64);
        chk("m1_nbursts", 64'(exp_ar.size()), 64'(1));
        chk("m1_arlen", 64'(exp_ar[0].len), 64'(15));
        chk("m1_nbeats", 64'(exp_beat.size()), 64'(16));
        run_cmd(32'h100, 64, 1'b0);

        // 4 KB crossing
        model_cmd(32'hFF8, 32);
        chk("m2_addr0", 64'(exp_ar[0].addr), 64'(32'hFF8));
        chk("m2_len0", 64'(exp_ar[0].len), 64'(1));
        chk("m2_addr1", 64'(exp_ar[1].addr), 64'(32'h1000));
        chk("m2_len1", 64'(exp_ar[1].len), 64'(5));
        run_cmd(32'hFF8, 32, 1'b0);

        // MAX_BURST splitting (50 beats) with an error response on one beat
        model_cmd(32'h0, 200);
        chk("m3_nbursts", 64'(exp_ar.size()), 64'(4));
        chk("m3_len0", 64'(exp_ar[0].len), 64'(15));
        chk("m3_len2", 64'(exp_ar[2].len), 64'(15));
        chk("m3_len3", 64'(exp_ar[3].len), 64'(1));
        chk("m3_addr1", 64'(exp_ar[1].addr), 64'(32'h40));
        chk("m3_addr3", 64'(exp_ar[3].addr), 64'(32'hC0));
        err_beat = beat_idx + 20;
        run_cmd(32'h0, 200, 1'b1);
        err_beat = -1;

        // out_ready toggling; err from the previous command must clear on accept
        out_tog = 1'b1;
        model_cmd(32'h200, 32);
        run_cmd(32'h200, 32, 1'b0);
        out_tog = 1'b0;

        // zero-length command
        issue_cmd(32'h300, 0);
        @(negedge clk);
        chk("z_done_c1", 64'(done), 64'(0));
        chk("z_arvalid_c1", 64'(arvalid), 64'(0));
        @(negedge clk);
        chk("z_done_c2", 64'(done), 64'(1));
        chk("z_arvalid_c2", 64'(arvalid), 64'(0));
        chk("z_err", 64'(err), 64'(0));
        @(negedge clk);
        chk("z_done_c3", 64'(done), 64'(0));
        chk("z_cmd_ready_c3", 64'(cmd_ready), 64'(1));

        // stalled AR then reset in the middle of the data phase
        ar_delay = 3;
        n_stall = 0;
        model_cmd(32'h100, 64);
        issue_cmd(32'h100, 64);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_fires >= 4 + 16 + 8 + 50 + 8) begin got = 1'b1; break; end
        end
        chk("r6_data_reached", 64'(got), 64'(1));
        chk("r6_stall_seen", 64'(n_stall > 0), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_ar.delete();
        exp_beat.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("r6_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("r6_arvalid", 64'(arvalid), 64'(0));
        chk("r6_out_valid", 64'(out_valid), 64'(0));
        chk("r6_out_last", 64'(out_last), 64'(0));
        chk("r6_done", 64'(done), 64'(0));
        chk("r6_err", 64'(err), 64'(0));
        chk("r6_rready", 64'(rready), 64'(1));
        ar_delay = 0;

        // recovery after reset
        model_cmd(32'h40, 16);
        run_cmd(32'h40, 16, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
